// File: rtl/assoc_cache_controller.sv
// ============================================================================
// assoc_cache_controller
//
// N-way set-associative, write-back, write-allocate cache controller with
// age-based LRU replacement. Holds the tag/valid/dirty/age arrays, the data
// array and the request FSM. A miss writes back a dirty victim block (if
// any) and then refills the block word-by-word over a req/ack memory port.
//
// Address layout (word address): {tag, index, offset}.
//
// Ports:
//   clk          - single clock, rising edge
//   rst_b        - synchronous reset, ACTIVE-HIGH despite the name
//   cpu_req      - request valid, sampled only while cpu_ready=1
//   cpu_we       - 1 = write, 0 = read
//   cpu_addr     - word address
//   cpu_wdata    - write data
//   cpu_ready    - controller idle and accepting
//   cpu_done     - one-cycle completion pulse
//   cpu_rdata    - read data, valid with cpu_done
//   hit_miss     - valid with cpu_done, 1 = hit
//   mem_req      - memory beat request, held until mem_ack
//   mem_we       - 1 = writeback beat, 0 = refill beat
//   mem_addr     - word address of the current beat
//   mem_wdata    - writeback data
//   mem_rdata    - refill data, valid with mem_ack
//   mem_ack      - beat complete, ignored while mem_req=0
//
// Optional feature (macro CACHE_STATS_EN): adds saturating 32-bit counters
// stat_hits / stat_misses, bumped on each cpu_done, cleared by rst_b.
// ============================================================================
module assoc_cache_controller #(
    parameter int ADDRESS_WORD_SIZE = 32,
    parameter int WORD_SIZE         = 8,
    parameter int BLOCK_SIZE        = 8,
    parameter int NUMBER_OF_SETS    = 128,
    parameter int NUM_WAYS          = 4
) (
    input  logic                         clk,
    input  logic                         rst_b,
    input  logic                         cpu_req,
    input  logic                         cpu_we,
    input  logic [ADDRESS_WORD_SIZE-1:0] cpu_addr,
    input  logic [WORD_SIZE-1:0]         cpu_wdata,
    output logic                         cpu_ready,
    output logic                         cpu_done,
    output logic [WORD_SIZE-1:0]         cpu_rdata,
    output logic                         hit_miss,
    output logic                         mem_req,
    output logic                         mem_we,
    output logic [ADDRESS_WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]         mem_wdata,
    input  logic [WORD_SIZE-1:0]         mem_rdata,
    input  logic                         mem_ack
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0]                  stat_hits,
    output logic [31:0]                  stat_misses
`endif
);

    localparam int OFFSET_W = $clog2(BLOCK_SIZE);
    localparam int INDEX_W  = $clog2(NUMBER_OF_SETS);
    localparam int AGE_W    = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam int TAG_SIZE = ADDRESS_WORD_SIZE - INDEX_W - OFFSET_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_WRITEBACK,
        ST_REFILL,
        ST_RESPOND
    } state_t;

    // Storage arrays
    logic [TAG_SIZE-1:0]  tag_q   [NUMBER_OF_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]  valid_q [NUMBER_OF_SETS];
    logic [NUM_WAYS-1:0]  dirty_q [NUMBER_OF_SETS];
    logic [AGE_W-1:0]     age_q   [NUMBER_OF_SETS][NUM_WAYS];
    logic [WORD_SIZE-1:0] data_q  [NUMBER_OF_SETS][NUM_WAYS][BLOCK_SIZE];

    // Control flops
    state_t                         state_q, state_d;
    logic                           cpu_ready_q, cpu_ready_d;
    logic                           cpu_done_q, cpu_done_d;
    logic [WORD_SIZE-1:0]           cpu_rdata_q, cpu_rdata_d;
    logic                           hit_miss_q, hit_miss_d;
    logic                           mem_req_q, mem_req_d;
    logic                           mem_we_q, mem_we_d;
    logic [ADDRESS_WORD_SIZE-1:0]   mem_addr_q, mem_addr_d;
    logic [WORD_SIZE-1:0]           mem_wdata_q, mem_wdata_d;

    // Request / datapath flops (no reset needed; always written before use)
    logic                           req_we_q, req_we_d;
    logic [ADDRESS_WORD_SIZE-1:0]   req_addr_q, req_addr_d;
    logic [WORD_SIZE-1:0]           req_wdata_q, req_wdata_d;
    logic [AGE_W-1:0]               way_q, way_d;
    logic [OFFSET_W-1:0]            beat_q, beat_d;
    logic                           hit_q, hit_d;

    logic [TAG_SIZE-1:0]  req_tag;
    logic [INDEX_W-1:0]   req_idx;
    logic [OFFSET_W-1:0]  req_off;
    logic [OFFSET_W-1:0]  beat_nxt;
    logic                 beat_last;
    logic                 beat_ack;

    logic                 hit_any;
    logic [AGE_W-1:0]     hit_way;
    logic                 vict_found;
    logic [AGE_W-1:0]     vict_way;
    logic [AGE_W-1:0]     age_upd [NUM_WAYS];

    logic                 data_we;
    logic [OFFSET_W-1:0]  data_off;
    logic [WORD_SIZE-1:0] data_wdata;
    logic                 fill_en;
    logic                 dirty_set;
    logic                 age_en;

    assign req_tag   = req_addr_q[ADDRESS_WORD_SIZE-1 -: TAG_SIZE];
    assign req_idx   = req_addr_q[OFFSET_W +: INDEX_W];
    assign req_off   = req_addr_q[OFFSET_W-1:0];
    assign beat_nxt  = beat_q + OFFSET_W'(1);
    assign beat_last = (beat_q == OFFSET_W'(BLOCK_SIZE - 1));
    assign beat_ack  = mem_req_q & mem_ack;

    // Tag match and victim choice for the latched request's set
    always_comb begin
        hit_any    = 1'b0;
        hit_way    = '0;
        vict_found = 1'b0;
        vict_way   = '0;
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (valid_q[req_idx][w] && (tag_q[req_idx][w] == req_tag)) begin
                hit_any = 1'b1;
                hit_way = AGE_W'(w);
            end
        end
        for (int w = 0; w < NUM_WAYS; w++) begin
            if (!vict_found && !valid_q[req_idx][w]) begin
                vict_found = 1'b1;
                vict_way   = AGE_W'(w);
            end
        end
        // Set full: evict the oldest way
        if (!vict_found) begin
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (age_q[req_idx][w] == AGE_W'(NUM_WAYS - 1)) begin
                    vict_way = AGE_W'(w);
                end
            end
        end
    end

    // Accessed way becomes youngest; only ways younger than it age by one,
    // so the set remains a permutation of 0..NUM_WAYS-1.
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            age_upd[w] = age_q[req_idx][w];
            if (AGE_W'(w) == way_q) begin
                age_upd[w] = '0;
            end else if (age_q[req_idx][w] < age_q[req_idx][way_q]) begin
                age_upd[w] = age_q[req_idx][w] + AGE_W'(1);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cpu_ready_d = cpu_ready_q;
        cpu_done_d  = 1'b0;
        cpu_rdata_d = cpu_rdata_q;
        hit_miss_d  = hit_miss_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        way_d       = way_q;
        beat_d      = beat_q;
        hit_d       = hit_q;
        data_we     = 1'b0;
        data_off    = beat_q;
        data_wdata  = mem_rdata;
        fill_en     = 1'b0;
        dirty_set   = 1'b0;
        age_en      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (cpu_req) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    cpu_ready_d = 1'b0;
                    state_d     = ST_LOOKUP;
                end
            end
            ST_LOOKUP: begin
                if (hit_any) begin
                    way_d   = hit_way;
                    hit_d   = 1'b1;
                    state_d = ST_RESPOND;
                end else begin
                    way_d     = vict_way;
                    hit_d     = 1'b0;
                    beat_d    = '0;
                    mem_req_d = 1'b1;
                    if (valid_q[req_idx][vict_way] && dirty_q[req_idx][vict_way]) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[req_idx][vict_way], req_idx, {OFFSET_W{1'b0}}};
                        mem_wdata_d = data_q[req_idx][vict_way][0];
                        state_d     = ST_WRITEBACK;
                    end else begin
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                        state_d    = ST_REFILL;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (beat_ack) begin
                    if (beat_last) begin
                        // Straight into the refill; mem_req stays high
                        beat_d     = '0;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {req_tag, req_idx, {OFFSET_W{1'b0}}};
                        state_d    = ST_REFILL;
                    end else begin
                        beat_d      = beat_nxt;
                        mem_addr_d  = {tag_q[req_idx][way_q], req_idx, beat_nxt};
                        mem_wdata_d = data_q[req_idx][way_q][beat_nxt];
                    end
                end
            end
            ST_REFILL: begin
                if (beat_ack) begin
                    data_we = 1'b1;
                    if (beat_last) begin
                        fill_en   = 1'b1;
                        mem_req_d = 1'b0;
                        state_d   = ST_RESPOND;
                    end else begin
                        beat_d     = beat_nxt;
                        mem_addr_d = {req_tag, req_idx, beat_nxt};
                    end
                end
            end
            ST_RESPOND: begin
                cpu_done_d  = 1'b1;
                hit_miss_d  = hit_q;
                cpu_ready_d = 1'b1;
                age_en      = 1'b1;
                if (req_we_q) begin
                    data_we    = 1'b1;
                    data_off   = req_off;
                    data_wdata = req_wdata_q;
                    dirty_set  = 1'b1;
                end else begin
                    cpu_rdata_d = data_q[req_idx][way_q][req_off];
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control register stage
    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q     <= ST_IDLE;
            cpu_ready_q <= 1'b1;
            cpu_done_q  <= 1'b0;
            cpu_rdata_q <= '0;
            hit_miss_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cpu_ready_q <= cpu_ready_d;
            cpu_done_q  <= cpu_done_d;
            cpu_rdata_q <= cpu_rdata_d;
            hit_miss_q  <= hit_miss_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Request / datapath register stage
    always_ff @(posedge clk) begin
        req_we_q    <= req_we_d;
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
        way_q       <= way_d;
        beat_q      <= beat_d;
        hit_q       <= hit_d;
    end

    // Metadata that must reset; valid is only set after the final refill beat,
    // so an aborted refill never becomes visible.
    always_ff @(posedge clk) begin
        if (rst_b) begin
            for (int s = 0; s < NUMBER_OF_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[s][w] <= AGE_W'(w);
                end
            end
        end else begin
            if (fill_en) begin
                valid_q[req_idx][way_q] <= 1'b1;
                dirty_q[req_idx][way_q] <= 1'b0;
            end
            if (dirty_set) begin
                dirty_q[req_idx][way_q] <= 1'b1;
            end
            if (age_en) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    age_q[req_idx][w] <= age_upd[w];
                end
            end
        end
    end

    // Tag and data storage, not reset
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_q[req_idx][way_q] <= req_tag;
        end
        if (data_we) begin
            data_q[req_idx][way_q][data_off] <= data_wdata;
        end
    end

`ifdef CACHE_STATS_EN
    logic [31:0] stat_hits_q, stat_hits_d;
    logic [31:0] stat_misses_q, stat_misses_d;

    always_comb begin
        stat_hits_d   = stat_hits_q;
        stat_misses_d = stat_misses_q;
        if (state_q == ST_RESPOND) begin
            if (hit_q) begin
                if (stat_hits_q != 32'hFFFF_FFFF) stat_hits_d = stat_hits_q + 32'd1;
            end else begin
                if (stat_misses_q != 32'hFFFF_FFFF) stat_misses_d = stat_misses_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            stat_hits_q   <= '0;
            stat_misses_q <= '0;
        end else begin
            stat_hits_q   <= stat_hits_d;
            stat_misses_q <= stat_misses_d;
        end
    end

    assign stat_hits   = stat_hits_q;
    assign stat_misses = stat_misses_q;
`endif

    assign cpu_ready = cpu_ready_q;
    assign cpu_done  = cpu_done_q;
    assign cpu_rdata = cpu_rdata_q;
    assign hit_miss  = hit_miss_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: doc/assoc_cache_controller.md
Name: assoc_cache_controller

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache controller with age-based LRU replacement.
- Contains the tag/valid/dirty/age arrays, the data array and a request FSM.
- Sits between the CPU-side request port and a burst memory port. A miss refills one block word-by-word over a req/ack handshake, after writing back a dirty victim if needed.

Parameters:
- ADDRESS_WORD_SIZE, 32, CPU address width in bits (word-addressed).
- WORD_SIZE, 8, data word width in bits.
- BLOCK_SIZE, 8, words per block; power of 2; OFFSET_W = log2(BLOCK_SIZE).
- NUMBER_OF_SETS, 128, sets; power of 2; INDEX_W = log2(NUMBER_OF_SETS).
- NUM_WAYS, 4, associativity; power of 2, 1..8; AGE_W = max(1, log2(NUM_WAYS)).
- Derived: TAG_SIZE = ADDRESS_WORD_SIZE - INDEX_W - OFFSET_W; address = {tag, index, offset}.

Ports:
- clk, input, 1, single clock; all logic on its rising edge.
- rst_b, input, 1, synchronous, active-high reset (the name is kept; the polarity is high).
- cpu_req, input, 1, request valid; sampled only while cpu_ready=1.
- cpu_we, input, 1, 1 = write, 0 = read.
- cpu_addr, input, ADDRESS_WORD_SIZE, word address.
- cpu_wdata, input, WORD_SIZE, write data.
- cpu_ready, output, 1, controller idle and accepting.
- cpu_done, output, 1, one-cycle pulse: operation complete.
- cpu_rdata, output, WORD_SIZE, read data; valid while cpu_done=1.
- hit_miss, output, 1, valid with cpu_done: 1 = hit, 0 = miss.
- mem_req, output, 1, memory beat request; held until mem_ack.
- mem_we, output, 1, 1 = writeback beat, 0 = refill beat.
- mem_addr, output, ADDRESS_WORD_SIZE, word address of the current beat.
- mem_wdata, output, WORD_SIZE, writeback data.
- mem_rdata, input, WORD_SIZE, refill data; valid with mem_ack.
- mem_ack, input, 1, beat complete; ignored while mem_req=0.

Behaviour:
- Reset (rst_b=1 at an edge):
  - FSM goes to IDLE.
  - All valid and dirty bits are cleared.
  - Ages in every set are set to age[w]=w.
  - Outputs: cpu_ready=1, cpu_done=0, cpu_rdata=0, hit_miss=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Data array contents are not reset.
  - Reset mid-operation aborts at that edge: no partial refill becomes valid, and mem_req=0 from the next cycle.
- FSM states: IDLE, LOOKUP, WRITEBACK, REFILL, RESPOND.
- IDLE:
  - cpu_ready=1.
  - On cpu_req=1, latch we/addr/wdata, go to LOOKUP, and drop cpu_ready at the next cycle.
- LOOKUP:
  - Compare the tag against all valid ways of the set.
  - Hit: go to RESPOND with hit_miss=1.
  - Miss, victim invalid or clean: go to REFILL.
  - Miss, victim valid and dirty: go to WRITEBACK.
  - Victim selection: the lowest-index invalid way; if all ways are valid, the way with age == NUM_WAYS-1.
- WRITEBACK:
  - BLOCK_SIZE beats with mem_we=1.
  - mem_addr = {victim tag, index, beat}, beats 0..BLOCK_SIZE-1.
  - Advance a beat on mem_ack.
  - After the last ack, go to REFILL.
- REFILL:
  - BLOCK_SIZE beats with mem_we=0.
  - mem_addr = {req tag, index, beat}.
  - On each mem_ack, write mem_rdata into the victim way.
  - After the last ack: set the tag, set valid, clear dirty, go to RESPOND with hit_miss=0.
- RESPOND (one cycle):
  - Read: cpu_rdata = the word.
  - Write: store cpu_wdata and set dirty.
  - Assert cpu_done and update the ages. Return to IDLE; cpu_ready=1 in the following cycle.
- Latency:
  - Hit: cpu_done 2 cycles after the accept edge.
  - Miss: cpu_done after 2 + memory-beat cycles.
- Age update on the accessed way a, with old age A:
  - every way with age < A increments;
  - a becomes 0;
  - others are unchanged.
  - Ages in each set stay a permutation of 0..NUM_WAYS-1. A hit on an age-0 way changes nothing.
- mem_req and mem_addr are held stable until mem_ack. Back-to-back beats are allowed: a new beat may be issued the cycle after an ack.
- cpu_req while cpu_ready=0 is ignored; it is not queued.
- NUM_WAYS=1: direct-mapped; the age logic is constant 0.

Optional Feature:
- Macro: CACHE_STATS_EN.
- Defined: adds outputs stat_hits[31:0] and stat_misses[31:0].
  - One of them increments on each cpu_done, according to hit_miss.
  - Both saturate at 0xFFFF_FFFF and are cleared by rst_b.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Bench configuration: defaults, so tag = addr[31:10], index = addr[9:3], offset = addr[2:0].
- Read miss then hit: reset, read 0x010, memory returns 0xA0+beat on beats addr 0x010..0x017.
  - First read: cpu_done with hit_miss=0, cpu_rdata=0xA0, and 8 refill beats with mem_we=0.
  - Repeat read: hit_miss=1, cpu_done 2 cycles after accept, no mem_req.
- Write hit then read back: write 0x013 = 0x5C (hit), then read 0x013 → cpu_rdata=0x5C, hit_miss=1, no memory traffic.
- LRU eviction with writeback:
  - Fill set 2 via 0x010 (dirty from the previous write), 0x410, 0x810, 0xC10.
  - Read 0x1010 → victim is the 0x010 way.
  - Expect 8 writeback beats at 0x010..0x017 with mem_wdata word 3 = 0x5C, then a refill at 0x1010..0x1017.
  - Read 0x410 → hit.
- Age ordering: after accessing 0x410, 0x810, 0xC10, 0x1010, re-access 0x810, then miss on 0x1410 → victim is the 0x410 way; re-read 0x810 hits.
- Reset mid-REFILL: assert rst_b after 3 refill acks for 0x020.
  - Next cycle: mem_req=0, cpu_ready=1.
  - Read 0x020 → miss with a full 8-beat refill.
- CACHE_STATS_EN: run the miss/hit pair, then 2 more hits → stat_hits=3, stat_misses=1; reset → both 0.
